// File: rtl/cpu_pkg.sv
// Shared types for the CPU / DMA memory arbiter.
//   addr_t, data_t      : memory address and data words
//   arb_state_t         : arbiter FSM state encoding
//   DMA_MAX_BURST_DEF   : default cap on consecutive locked DMA grants
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    PREF_CPU  = 2'd0,
    PREF_DMA  = 2'd1,
    DMA_BURST = 2'd2
  } arb_state_t;

  localparam int DMA_MAX_BURST_DEF = 16;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, DMA) arbiter in front of a single-port memory with
// registered read data.
//
// Handshake: a requester holds req (with we/addr/wdata stable) until its gnt
// is seen high; gnt is combinational and the access is committed at the same
// posedge. A granted read returns its data on <owner>_rvalid exactly one cycle
// later; <owner>_rdata is zero whenever <owner>_rvalid is low.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   cpu_req/we/addr/wdata      CPU request side
//   cpu_gnt/rvalid/rdata       CPU response side
//   dma_*                      same as cpu_*, for the DMA/loader
//   dma_lock                   with a DMA grant: keep the port next cycle
//   mem_mw/addr/wdata          memory command
//   mem_rdata                  memory read data (one cycle after address)
//   dbg_state, dbg_burst_cnt   FSM state and burst counter for observation
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int DMA_MAX_BURST = DMA_MAX_BURST_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  addr_t      cpu_addr,
  input  data_t      cpu_wdata,
  output logic       cpu_gnt,
  output logic       cpu_rvalid,
  output data_t      cpu_rdata,
  input  logic       dma_req,
  input  logic       dma_we,
  input  addr_t      dma_addr,
  input  data_t      dma_wdata,
  input  logic       dma_lock,
  output logic       dma_gnt,
  output logic       dma_rvalid,
  output data_t      dma_rdata,
  output logic       mem_mw,
  output addr_t      mem_addr,
  output data_t      mem_wdata,
  input  data_t      mem_rdata,
  output logic [1:0] dbg_state,
  output logic [7:0] dbg_burst_cnt
);

  localparam logic [7:0] BURST_LIMIT = 8'(DMA_MAX_BURST);

  arb_state_t state, state_next;
  logic [7:0] burst_cnt, burst_cnt_next;
  logic [7:0] burst_inc;
  logic       cpu_rd_pend, dma_rd_pend;

  assign burst_inc = burst_cnt + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PREF_CPU;
      burst_cnt <= 8'd0;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    burst_cnt_next = burst_cnt;
    cpu_gnt        = 1'b0;
    dma_gnt        = 1'b0;
    // Grants are suppressed while reset is held, whatever the requests say.
    if (!reset) begin
      case (state)
        PREF_CPU: begin
          if (cpu_req) begin
            cpu_gnt = 1'b1;
            if (dma_req) state_next = PREF_DMA;
          end else if (dma_req) begin
            dma_gnt    = 1'b1;
            state_next = dma_lock ? DMA_BURST : PREF_CPU;
          end
        end
        PREF_DMA: begin
          if (dma_req) begin
            dma_gnt    = 1'b1;
            state_next = dma_lock ? DMA_BURST : PREF_CPU;
          end else if (cpu_req) begin
            cpu_gnt = 1'b1;
          end
        end
        DMA_BURST: begin
          if (dma_req) begin
            dma_gnt = 1'b1;
            if (!dma_lock) begin
              state_next = PREF_CPU;
            end else begin
              // Counting up to the limit forces an exit, so the counter
              // can never wrap.
              burst_cnt_next = burst_inc;
              if (burst_inc >= BURST_LIMIT) state_next = PREF_CPU;
            end
          end else begin
            // DMA released the port: the CPU may use this same cycle.
            cpu_gnt    = cpu_req;
            state_next = PREF_CPU;
          end
        end
        default: state_next = PREF_CPU;
      endcase
      if (state_next == DMA_BURST && state != DMA_BURST) burst_cnt_next = 8'd0;
    end
  end

  // Memory command mux; the idle default is a harmless read at cpu_addr.
  always_comb begin
    mem_mw    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_mw    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_mw    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // Owner pipeline: remembers who issued last cycle's read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rd_pend <= 1'b0;
      dma_rd_pend <= 1'b0;
    end else begin
      cpu_rd_pend <= cpu_gnt & ~cpu_we;
      dma_rd_pend <= dma_gnt & ~dma_we;
    end
  end

  assign cpu_rvalid = cpu_rd_pend;
  assign dma_rvalid = dma_rd_pend;
  assign cpu_rdata  = cpu_rd_pend ? mem_rdata : '0;
  assign dma_rdata  = dma_rd_pend ? mem_rdata : '0;

  assign dbg_state     = state;
  assign dbg_burst_cnt = burst_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  addr_t      cpu_addr = '0;
  data_t      cpu_wdata = '0;
  logic       cpu_gnt, cpu_rvalid;
  data_t      cpu_rdata;
  logic       dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
  addr_t      dma_addr = '0;
  data_t      dma_wdata = '0;
  logic       dma_gnt, dma_rvalid;
  data_t      dma_rdata;
  logic       mem_mw;
  addr_t      mem_addr;
  data_t      mem_wdata;
  data_t      mem_rdata = '0;
  logic [1:0] dbg_state;
  logic [7:0] dbg_burst_cnt;

  mem_arbiter #(.DMA_MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_mw(mem_mw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_burst_cnt(dbg_burst_cnt)
  );

  // Single-port memory with registered read data.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_mw) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic cpu_drive(input logic req, input logic we, input logic [15:0] addr,
                           input logic [7:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic dma_drive(input logic req, input logic we, input logic [15:0] addr,
                           input logic [7:0] wd, input logic lock);
    dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wd; dma_lock = lock;
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  logic [1:0] st_pat3 [8];
  logic [7:0] cpu_pat3 = 8'b0100_0001;
  logic [9:0] cpu_pat4 = 10'b00_0100_0001;

  initial begin
    int dma_idx;
    int run;
    logic prev_c, exp_c;

    st_pat3 = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1};

    // ---- reset state, requests ignored ----
    @(negedge clk);
    cpu_drive(1, 1, 16'h0010, 8'h01); dma_drive(1, 1, 16'h0020, 8'h02, 1); #1;
    check("rst_cpu_gnt", 32'(cpu_gnt), 0);
    check("rst_dma_gnt", 32'(dma_gnt), 0);
    check("rst_mem_mw", 32'(mem_mw), 0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("rst_dma_rvalid", 32'(dma_rvalid), 0);
    check("rst_state", 32'(dbg_state), 0);
    check("rst_burst_cnt", 32'(dbg_burst_cnt), 0);
    @(negedge clk);
    reset = 1'b0;
    cpu_drive(0, 0, 16'h0000, 8'h00); dma_drive(0, 0, 16'h0000, 8'h00, 0); #1;
    check("rel_state", 32'(dbg_state), 0);

    // ---- CPU write then read-back ----
    @(negedge clk); cpu_drive(1, 1, 16'h0200, 8'h12); #1;
    check("wr_cpu_gnt", 32'(cpu_gnt), 1);
    check("wr_mem_mw", 32'(mem_mw), 1);
    check("wr_mem_addr", 32'(mem_addr), 'h0200);
    check("wr_mem_wdata", 32'(mem_wdata), 'h12);
    check("wr_dma_gnt", 32'(dma_gnt), 0);
    @(negedge clk); cpu_drive(1, 0, 16'h0200, 8'h00); #1;
    check("rd_cpu_gnt", 32'(cpu_gnt), 1);
    check("rd_mem_mw", 32'(mem_mw), 0);
    check("wr_no_rvalid", 32'(cpu_rvalid), 0);
    @(negedge clk); cpu_drive(0, 0, 16'h0000, 8'h00); #1;
    check("rb_cpu_rvalid", 32'(cpu_rvalid), 1);
    check("rb_cpu_rdata", 32'(cpu_rdata), 'h12);
    check("rb_dma_rvalid", 32'(dma_rvalid), 0);
    check("rb_dma_rdata", 32'(dma_rdata), 0);
    @(negedge clk); cpu_drive(1, 1, 16'h0100, 8'h5A); #1;
    check("pulse_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("pulse_cpu_rdata", 32'(cpu_rdata), 0);
    check("cpu_only_state", 32'(dbg_state), 0);
    @(negedge clk); cpu_drive(1, 1, 16'h0101, 8'hC3); #1;
    check("pre_cpu_gnt", 32'(cpu_gnt), 1);

    // ---- both reading, no lock: alternate C, D, C, D ----
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_drive(1, 0, 16'h0100, 8'h00); dma_drive(1, 0, 16'h0101, 8'h00, 0); #1;
      check("alt_cpu_gnt", 32'(cpu_gnt), (i % 2 == 0) ? 1 : 0);
      check("alt_dma_gnt", 32'(dma_gnt), (i % 2 == 1) ? 1 : 0);
      check("alt_cpu_rvalid", 32'(cpu_rvalid), (i % 2 == 1) ? 1 : 0);
      check("alt_cpu_rdata", 32'(cpu_rdata), (i % 2 == 1) ? 'h5A : 0);
      check("alt_dma_rvalid", 32'(dma_rvalid), (i == 2) ? 1 : 0);
      check("alt_dma_rdata", 32'(dma_rdata), (i == 2) ? 'hC3 : 0);
    end
    @(negedge clk); cpu_drive(0, 0, 16'h0000, 8'h00); dma_drive(0, 0, 16'h0000, 8'h00, 0); #1;
    check("alt_last_dma_rvalid", 32'(dma_rvalid), 1);
    check("alt_last_dma_rdata", 32'(dma_rdata), 'hC3);
    check("alt_end_state", 32'(dbg_state), 0);

    // ---- locked burst with limit 4 ----
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cpu_drive(1, 0, 16'h0100, 8'h00); dma_drive(1, 0, 16'h0101, 8'h00, 1); #1;
      check("burst_cpu_gnt", 32'(cpu_gnt), 32'(cpu_pat3[i]));
      check("burst_dma_gnt", 32'(dma_gnt), 32'(!cpu_pat3[i]));
      check("burst_state", 32'(dbg_state), 32'(st_pat3[i]));
      if (i >= 2 && i <= 5) check("burst_cnt", 32'(dbg_burst_cnt), i - 2);
    end
    @(negedge clk); dma_drive(0, 0, 16'h0000, 8'h00, 0); #1;
    check("burst_release_cpu_gnt", 32'(cpu_gnt), 1);
    check("burst_release_state", 32'(dbg_state), 2);
    @(negedge clk); cpu_drive(0, 0, 16'h0000, 8'h00); #1;
    check("burst_exit_state", 32'(dbg_state), 0);

    // ---- locked DMA writes 0x0300..0x0307 while CPU keeps requesting ----
    dma_idx = 0; run = 0; prev_c = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cpu_drive(1, 0, 16'h0100, 8'h00);
      dma_drive(dma_idx < 8, 1, 16'h0300 + 16'(dma_idx), 8'hAA, 1); #1;
      exp_c = cpu_pat4[i];
      check("fill_cpu_gnt", 32'(cpu_gnt), 32'(exp_c));
      check("fill_dma_gnt", 32'(dma_gnt), 32'(!exp_c));
      check("fill_cpu_rvalid", 32'(cpu_rvalid), 32'(prev_c));
      if (dma_gnt) begin
        dma_idx++;
        run++;
      end else begin
        run = 0;
      end
      check("fill_run_bound", 32'(run > 5), 0);
      prev_c = exp_c;
    end
    check("fill_count", dma_idx, 8);
    @(negedge clk); dma_drive(0, 0, 16'h0000, 8'h00, 0); cpu_drive(1, 0, 16'h0300, 8'h00); #1;
    check("fill_rel_cpu_gnt", 32'(cpu_gnt), 1);
    check("fill_rel_state", 32'(dbg_state), 2);
    @(negedge clk); cpu_drive(1, 0, 16'h0307, 8'h00); #1;
    check("fill_rd0_rvalid", 32'(cpu_rvalid), 1);
    check("fill_rd0_rdata", 32'(cpu_rdata), 'hAA);
    check("fill_rd0_state", 32'(dbg_state), 0);
    @(negedge clk); cpu_drive(0, 0, 16'h0000, 8'h00); #1;
    check("fill_rd7_rdata", 32'(cpu_rdata), 'hAA);
    for (int i = 0; i < 8; i++) check("fill_mem", 32'(mem[16'h0300 + 16'(i)]), 'hAA);

    // ---- reset in the cycle after a granted DMA read ----
    @(negedge clk); dma_drive(1, 0, 16'h0101, 8'h00, 0); #1;
    check("rr_dma_gnt", 32'(dma_gnt), 1);
    check("rr_cpu_gnt", 32'(cpu_gnt), 0);
    @(negedge clk);
    reset = 1'b1;
    cpu_drive(1, 1, 16'h0400, 8'h11); dma_drive(1, 1, 16'h0500, 8'h22, 1); #1;
    check("rr_dma_rvalid", 32'(dma_rvalid), 0);
    check("rr_dma_rdata", 32'(dma_rdata), 0);
    check("rr_gnt_cpu", 32'(cpu_gnt), 0);
    check("rr_gnt_dma", 32'(dma_gnt), 0);
    check("rr_mem_mw", 32'(mem_mw), 0);
    @(negedge clk); #1;
    check("rr_hold_gnt_cpu", 32'(cpu_gnt), 0);
    check("rr_hold_gnt_dma", 32'(dma_gnt), 0);
    check("rr_hold_state", 32'(dbg_state), 0);
    @(negedge clk);
    reset = 1'b0;
    cpu_drive(0, 0, 16'h0000, 8'h00); dma_drive(0, 0, 16'h0000, 8'h00, 0); #1;
    check("rr_rel_dma_rvalid", 32'(dma_rvalid), 0);
    check("rr_rel_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("rr_rel_state", 32'(dbg_state), 0);
    @(negedge clk); #1;
    check("rr_post_dma_rvalid", 32'(dma_rvalid), 0);
    @(negedge clk);
    cpu_drive(1, 1, 16'h0400, 8'h77); dma_drive(1, 0, 16'h0101, 8'h00, 0); #1;
    check("rr_first_cpu_gnt", 32'(cpu_gnt), 1);
    check("rr_first_dma_gnt", 32'(dma_gnt), 0);
    check("rr_first_mem_mw", 32'(mem_mw), 1);

    // ---- idle: harmless read at cpu_addr, state held for 100 cycles ----
    @(negedge clk);
    cpu_drive(0, 1, 16'h0123, 8'h55); dma_drive(0, 1, 16'h0456, 8'h66, 1); #1;
    check("idle_mem_mw", 32'(mem_mw), 0);
    check("idle_mem_addr", 32'(mem_addr), 'h0123);
    check("idle_mem_wdata", 32'(mem_wdata), 0);
    check("idle_state", 32'(dbg_state), 1);
    check("idle_cpu_rvalid", 32'(cpu_rvalid), 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      check("idle_loop_mw", 32'(mem_mw), 0);
      check("idle_loop_cpu_rvalid", 32'(cpu_rvalid), 0);
      check("idle_loop_dma_rvalid", 32'(dma_rvalid), 0);
      check("idle_loop_state", 32'(dbg_state), 1);
    end
    check("idle_mem_0400", 32'(mem[16'h0400]), 'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
